controlador_vitais: RTL and testbench
=====================================

Name: controlador_vitais

Overview:
- Parametrised successor to the fixed three-attribute pet engine: N independent vital channels (hunger, happiness, sleep, ...), each WIDTH bits wide.
- Each channel decays at its own programmable rate, is raised or lowered by button-driven actions through a valid/ready port, and saturates at both ends.
- Adds behaviour the fixed engine lacks: per-channel critical flags, a grace period before death, a frozen DEAD state and a revive command.
- Sits between the state controller, which issues actions, and the image and display controllers, which read attr_bus, critico and morreu.

Parameters:
N_ATTR, 3, number of vital channels (1..8)
WIDTH, 8, bits per channel value
TICK_DIV, 25000000, clk cycles per game tick (>=2)
DECAY_PER, {16'd10,16'd20,16'd30}, packed N_ATTR x 16-bit ticks per 1-unit decay, channel 0 in LSBs (value 0 = channel never decays)
INIT_VAL, 2**WIDTH-1, value loaded on reset and revive
LIMIAR, 2**(WIDTH-2), critical threshold
GRACE_TICKS, 5, consecutive ticks with any channel at 0 before death

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
pausa  in  1  1 = freeze prescaler, decay and grace counters; actions still accepted
acao_valid  in  1  action request
acao_ready  out  1  action accepted when valid&ready
acao_canal  in  $clog2(N_ATTR) (min 1)  target channel
acao_delta  in  WIDTH  magnitude
acao_sub  in  1  0 = add, 1 = subtract
reviver  in  1  single-cycle pulse; honoured only in DEAD
attr_bus  out  N_ATTR*WIDTH  channel values, channel 0 in LSBs
critico  out  N_ATTR  per-channel flag: value <= LIMIAR
morreu  out  1  high while in DEAD
erro_canal  out  1  1-cycle pulse when an accepted action has acao_canal >= N_ATTR
tick  out  1  1-cycle game-tick strobe for other blocks

Behaviour:
Reset (rst=1 at an edge) applies regardless of state or any operation in flight:
- every channel = INIT_VAL; critico = 0 (INIT_VAL > LIMIAR is required); morreu = 0; erro_canal = 0; tick = 0
- prescaler, decay counters and grace counter = 0; FSM = VIVO

FSM states:
- VIVO: normal operation; acao_ready = 1.
- MORTO: acao_ready = 0; values, counters and critico held; morreu = 1.
- VIVO->MORTO: the grace counter reaches GRACE_TICKS.
- MORTO->VIVO: reviver=1. Same reload as reset but prescaler not cleared; morreu falls on the next edge.
- reviver while in VIVO is ignored.

Prescaler and tick:
- Counts 0..TICK_DIV-1 when pausa=0 and state=VIVO.
- tick is registered and high for the one cycle after the count wraps to 0.
- Internal decay and grace logic uses the same wrap event.

Decay:
- Each channel i has a 16-bit counter, incremented on each tick event.
- On reaching DECAY_PER[i]-1 the counter clears and the channel requests a -1 step.

Actions:
- Accepted at edge E; new value visible on attr_bus at E+1.
- Same-cycle decay step and action on one channel combine in one update: next = clamp(val ± delta − 1, 0, 2^WIDTH−1), computed at WIDTH+2 bits signed.
- Add saturates at max; subtract saturates at 0.
- Invalid channel: no value changes; erro_canal pulses at E+1.

critico and grace:
- critico is registered from the next value (same cycle as attr_bus).
- Grace counter: on each tick event, if any channel == 0 it increments; otherwise it clears.
- An action lifting every channel above 0 clears the grace counter at the next tick event.
- Death asserts at the edge where the counter would equal GRACE_TICKS.
- Action and death at the same edge: the action is applied, then the state freezes.

pausa: stalls the prescaler, so tick does not fire and decay/grace do not advance.

Decomposition:
- Package vitais_pkg: FSM state enum (VIVO, MORTO); sat_add/sat_sub functions; helper to extract the DECAY_PER slice.
- Sub-module canal_vital (one value register, its decay counter, and the clamp update) instantiated N_ATTR times via generate.
- Top handles prescaler, grace counter, FSM, action decode and erro_canal.

Test Plan:
- Reset/decay (TICK_DIV=4, DECAY_PER={3,2,1}, WIDTH=8) -> attr_bus = FF,FF,FF after reset; after 6 ticks channels = F9,FC,FD; tick period 4 clk.
- Saturation: add delta=0x10 to ch0 at FF -> stays FF; subtract 0x20 from ch1 at 0x10 -> 0x00; critico[1] = 1 in the same cycle the value appears.
- Collision: ch0 = 0x05 and a decay step and subtract 0x05 at the same edge -> 0x00, not wrap; add 0x03 with decay -> 0x07.
- Death/grace (GRACE_TICKS=5): force ch2 = 0 -> morreu rises exactly 5 tick events later; lifting ch2 to 1 before the 5th tick -> no death, counter restarts.
- MORTO behaviour: acao_ready = 0, values frozen 20 ticks; reviver -> all FF, morreu = 0 next cycle; reviver in VIVO -> no effect.
- Error and reset: acao_canal = 3 with N_ATTR=3 -> erro_canal 1-cycle pulse, bus unchanged; rst mid-collision -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/vitais_pkg.sv
// Shared types and helpers for the vital-channel engine: FSM states,
// saturating arithmetic and extraction of per-channel decay periods.
package vitais_pkg;

    typedef enum logic {
        VIVO  = 1'b0,
        MORTO = 1'b1
    } estado_t;

    localparam int MAX_ATTR = 8;
    localparam int PER_W    = 16;

    function automatic int sat_add(input int a, input int b, input int maxv);
        return (a + b > maxv) ? maxv : a + b;
    endfunction

    function automatic int sat_sub(input int a, input int b);
        return (a < b) ? 0 : a - b;
    endfunction

    function automatic logic [PER_W-1:0] decay_slice(input logic [MAX_ATTR*PER_W-1:0] per,
                                                     input int idx);
        return per[idx*PER_W +: PER_W];
    endfunction

endpackage

// File: rtl/canal_vital.sv
// One vital channel: value register, decay counter and the combined clamp update.
// Action and decay step land together in one cycle; new value and critico appear one edge later.
module canal_vital
    import vitais_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [PER_W-1:0] PER      = 16'd10,
    parameter int               INIT_VAL = 2**WIDTH - 1,
    parameter int               LIMIAR   = 2**(WIDTH - 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             recarga,
    input  logic             tick_ev,
    input  logic             acao_en,
    input  logic             acao_sub,
    input  logic [WIDTH-1:0] acao_delta,
    output logic [WIDTH-1:0] valor,
    output logic             critico
);

    localparam int               MAXV = 2**WIDTH - 1;
    localparam logic [WIDTH-1:0] INIT = WIDTH'(INIT_VAL);
    localparam logic [WIDTH-1:0] LIM  = WIDTH'(LIMIAR);

    logic [PER_W-1:0] cnt;
    logic             passo;
    int               liquido;
    logic [WIDTH-1:0] prox;

    // A zero period disables decay for this channel entirely.
    assign passo = tick_ev && (PER != '0) && (cnt == PER - 16'd1);

    always_comb begin
        liquido = 0;
        if (acao_en) begin
            liquido = acao_sub ? -int'(acao_delta) : int'(acao_delta);
        end
        if (passo) begin
            liquido = liquido - 1;
        end
        if (liquido >= 0) begin
            prox = WIDTH'(sat_add(int'(valor), liquido, MAXV));
        end else begin
            prox = WIDTH'(sat_sub(int'(valor), -liquido));
        end
    end

    always_ff @(posedge clk) begin
        if (rst || recarga) begin
            cnt     <= '0;
            valor   <= INIT;
            critico <= 1'b0;
        end else begin
            if (tick_ev && (PER != '0)) begin
                cnt <= passo ? '0 : cnt + 16'd1;
            end
            if (passo || acao_en) begin
                valor   <= prox;
                critico <= (prox <= LIM);
            end
        end
    end

endmodule

// File: rtl/controlador_vitais.sv
// N-channel vital engine: prescaler/tick, grace-to-death FSM, action decode and error pulse.
// Actions take effect one edge after acceptance; acao_ready drops while dead (no queuing).
module controlador_vitais
    import vitais_pkg::*;
#(
    parameter int                   N_ATTR      = 3,
    parameter int                   WIDTH       = 8,
    parameter int                   TICK_DIV    = 25000000,
    parameter logic [N_ATTR*16-1:0] DECAY_PER   = {16'd10, 16'd20, 16'd30},
    parameter int                   INIT_VAL    = 2**WIDTH - 1,
    parameter int                   LIMIAR      = 2**(WIDTH - 2),
    parameter int                   GRACE_TICKS = 5,
    localparam int                  CW          = (N_ATTR > 1) ? $clog2(N_ATTR) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pausa,
    input  logic                    acao_valid,
    output logic                    acao_ready,
    input  logic [CW-1:0]           acao_canal,
    input  logic [WIDTH-1:0]        acao_delta,
    input  logic                    acao_sub,
    input  logic                    reviver,
    output logic [N_ATTR*WIDTH-1:0] attr_bus,
    output logic [N_ATTR-1:0]       critico,
    output logic                    morreu,
    output logic                    erro_canal,
    output logic                    tick
);

    localparam int                          PW      = $clog2(TICK_DIV);
    localparam logic [PW-1:0]               PRE_MAX = PW'(TICK_DIV - 1);
    localparam int                          GW      = $clog2(GRACE_TICKS + 1);
    localparam logic [GW-1:0]               G_LAST  = GW'(GRACE_TICKS - 1);
    localparam logic [MAX_ATTR*PER_W-1:0]   PER_EXT = (MAX_ATTR*PER_W)'(DECAY_PER);

    estado_t           estado, prox_estado;
    logic [PW-1:0]     pre_cnt;
    logic [GW-1:0]     gcnt;
    logic              ativo, tick_ev, aceita, canal_ok, recarga, any_zero;
    logic [N_ATTR-1:0] zero_vec;

    assign ativo      = (estado == VIVO) && !pausa;
    assign tick_ev    = ativo && (pre_cnt == PRE_MAX);
    assign acao_ready = (estado == VIVO);
    assign aceita     = acao_valid && acao_ready;
    assign canal_ok   = 32'(acao_canal) < N_ATTR;
    assign recarga    = (estado == MORTO) && reviver;
    assign morreu     = (estado == MORTO);
    assign any_zero   = |zero_vec;

    for (genvar i = 0; i < N_ATTR; i++) begin : g_canal
        canal_vital #(
            .WIDTH    (WIDTH),
            .PER      (decay_slice(PER_EXT, i)),
            .INIT_VAL (INIT_VAL),
            .LIMIAR   (LIMIAR)
        ) u_canal (
            .clk        (clk),
            .rst        (rst),
            .recarga    (recarga),
            .tick_ev    (tick_ev),
            .acao_en    (aceita && canal_ok && (32'(acao_canal) == i)),
            .acao_sub   (acao_sub),
            .acao_delta (acao_delta),
            .valor      (attr_bus[i*WIDTH +: WIDTH]),
            .critico    (critico[i])
        );
        assign zero_vec[i] = (attr_bus[i*WIDTH +: WIDTH] == '0);
    end

    always_comb begin
        prox_estado = estado;
        case (estado)
            VIVO:  if (tick_ev && any_zero && (gcnt == G_LAST)) prox_estado = MORTO;
            MORTO: if (reviver) prox_estado = VIVO;
            default: prox_estado = VIVO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado     <= VIVO;
            pre_cnt    <= '0;
            gcnt       <= '0;
            tick       <= 1'b0;
            erro_canal <= 1'b0;
        end else begin
            estado     <= prox_estado;
            tick       <= tick_ev;
            erro_canal <= aceita && !canal_ok;
            if (tick_ev) begin
                pre_cnt <= '0;
            end else if (ativo) begin
                pre_cnt <= pre_cnt + 1'b1;
            end
            // Revive keeps the prescaler phase but restarts the grace window.
            if (recarga) begin
                gcnt <= '0;
            end else if (tick_ev) begin
                gcnt <= any_zero ? gcnt + 1'b1 : '0;
            end
        end
    end

endmodule

// File: tb/tb_controlador_vitais.sv
// Directed bench for controlador_vitais with a short prescaler and decay periods {3,2,1}.
module tb_controlador_vitais;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pausa = 1'b0;
    logic        acao_valid = 1'b0;
    logic        acao_ready;
    logic [1:0]  acao_canal = '0;
    logic [7:0]  acao_delta = '0;
    logic        acao_sub = 1'b0;
    logic        reviver = 1'b0;
    logic [23:0] attr_bus;
    logic [2:0]  critico;
    logic        morreu, erro_canal, tick;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    controlador_vitais #(
        .N_ATTR      (3),
        .WIDTH       (8),
        .TICK_DIV    (4),
        .DECAY_PER   ({16'd3, 16'd2, 16'd1}),
        .GRACE_TICKS (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pausa      (pausa),
        .acao_valid (acao_valid),
        .acao_ready (acao_ready),
        .acao_canal (acao_canal),
        .acao_delta (acao_delta),
        .acao_sub   (acao_sub),
        .reviver    (reviver),
        .attr_bus   (attr_bus),
        .critico    (critico),
        .morreu     (morreu),
        .erro_canal (erro_canal),
        .tick       (tick)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic acao(input int c, input logic [7:0] d, input logic s);
        acao_canal = 2'(c);
        acao_delta = d;
        acao_sub   = s;
        acao_valid = 1'b1;
        cyc();
        acao_valid = 1'b0;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!tick && n < 20);
        if (!tick) chk("tick_timeout", 32'(tick), 32'd1);
    endtask

    task automatic run(input int k);
        int n;
        pausa = 1'b0;
        repeat (k) wait_tick(n);
        pausa = 1'b1;
    endtask

    // Prescaler sits at 0 while paused, so the 4th edge after unpausing is the wrap.
    task automatic collide(input int c, input logic [7:0] d, input logic s,
                           input logic [7:0] pre, input logic [7:0] exp, input string tag);
        pausa = 1'b0;
        repeat (3) cyc();
        chk({tag, "_pre"}, 32'(attr_bus[c*8 +: 8]), 32'(pre));
        acao_canal = 2'(c);
        acao_delta = d;
        acao_sub   = s;
        acao_valid = 1'b1;
        cyc();
        acao_valid = 1'b0;
        pausa      = 1'b1;
        chk(tag, 32'(attr_bus[c*8 +: 8]), 32'(exp));
        chk({tag, "_tick"}, 32'(tick), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int ticks;

        repeat (3) cyc();
        rst = 1'b0;
        chk("rst_bus",    32'(attr_bus),   32'hFFFFFF);
        chk("rst_crit",   32'(critico),    32'd0);
        chk("rst_morreu", 32'(morreu),     32'd0);
        chk("rst_erro",   32'(erro_canal), 32'd0);
        chk("rst_tick",   32'(tick),       32'd0);
        chk("rst_ready",  32'(acao_ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            wait_tick(n);
            chk("tick_period", n, 32'd4);
        end
        chk("decay_6", 32'(attr_bus), 32'hFDFCF9);
        pausa = 1'b1;
        cyc();
        chk("tick_pulse", 32'(tick), 32'd0);

        acao(0, 8'h10, 1'b0);
        chk("sat_add_a", 32'(attr_bus[7:0]), 32'hFF);
        acao(0, 8'h10, 1'b0);
        chk("sat_add_b", 32'(attr_bus[7:0]), 32'hFF);
        chk("crit_none", 32'(critico), 32'd0);
        acao(1, 8'hEC, 1'b1);
        chk("sub_to_10", 32'(attr_bus[15:8]), 32'h10);
        chk("crit_10",   32'(critico), 32'b010);
        acao(1, 8'h20, 1'b1);
        chk("sat_sub",   32'(attr_bus[15:8]), 32'h00);
        chk("crit_0",    32'(critico), 32'b010);
        acao(1, 8'h80, 0);
        chk("crit_clr",  32'(critico), 32'd0);

        acao(3, 8'h05, 1'b0);
        chk("erro_pulse", 32'(erro_canal), 32'd1);
        chk("erro_bus",   32'(attr_bus), 32'hFD80FF);
        cyc();
        chk("erro_fall",  32'(erro_canal), 32'd0);

        acao(0, 8'hFA, 1'b1);
        chk("ch0_05", 32'(attr_bus[7:0]), 32'h05);
        collide(0, 8'h03, 1'b0, 8'h05, 8'h07, "col_add");
        acao(0, 8'h02, 1'b1);
        collide(0, 8'h05, 1'b1, 8'h05, 8'h00, "col_sub");
        acao(0, 8'h10, 1'b0);

        pausa = 1'b0;
        repeat (3) cyc();
        acao_canal = 2'd0;
        acao_delta = 8'h10;
        acao_sub   = 1'b1;
        acao_valid = 1'b1;
        rst        = 1'b1;
        cyc();
        acao_valid = 1'b0;
        pausa      = 1'b1;
        chk("mid_rst_bus",    32'(attr_bus),   32'hFFFFFF);
        chk("mid_rst_crit",   32'(critico),    32'd0);
        chk("mid_rst_tick",   32'(tick),       32'd0);
        chk("mid_rst_erro",   32'(erro_canal), 32'd0);
        chk("mid_rst_morreu", 32'(morreu),     32'd0);
        rst = 1'b0;

        acao(2, 8'hFF, 1'b1);
        chk("ch2_zero", 32'(attr_bus[23:16]), 32'h00);
        for (int i = 0; i < 4; i++) begin
            run(1);
            chk("grace_a", 32'(morreu), 32'd0);
        end
        acao(2, 8'h10, 1'b0);
        chk("ch2_lift", 32'(attr_bus[23:16]), 32'h10);
        run(1);
        chk("grace_clr", 32'(morreu), 32'd0);
        acao(2, 8'h10, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run(1);
            chk("grace_b", 32'(morreu), 32'd0);
        end
        run(1);
        chk("death",       32'(morreu),     32'd1);
        chk("death_bus",   32'(attr_bus),   32'h00FAF5);
        chk("death_crit",  32'(critico),    32'b100);
        chk("death_ready", 32'(acao_ready), 32'd0);

        pausa      = 1'b0;
        acao_canal = 2'd0;
        acao_delta = 8'h05;
        acao_sub   = 1'b0;
        acao_valid = 1'b1;
        ticks = 0;
        repeat (80) begin
            cyc();
            if (tick) ticks++;
        end
        acao_valid = 1'b0;
        chk("dead_ticks",  ticks, 32'd0);
        chk("dead_bus",    32'(attr_bus),   32'h00FAF5);
        chk("dead_morreu", 32'(morreu),     32'd1);
        chk("dead_crit",   32'(critico),    32'b100);

        pausa   = 1'b1;
        reviver = 1'b1;
        cyc();
        reviver = 1'b0;
        chk("rev_bus",    32'(attr_bus),   32'hFFFFFF);
        chk("rev_morreu", 32'(morreu),     32'd0);
        chk("rev_crit",   32'(critico),    32'd0);
        chk("rev_ready",  32'(acao_ready), 32'd1);

        acao(1, 8'h10, 1'b1);
        chk("alive_sub", 32'(attr_bus), 32'hFFEFFF);
        reviver = 1'b1;
        cyc();
        reviver = 1'b0;
        chk("rev_ignored",        32'(attr_bus), 32'hFFEFFF);
        chk("rev_ignored_morreu", 32'(morreu),   32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
